dual_dispatch: RTL and testbench
================================

Name: dual_dispatch

Overview:
- In-order two-wide dispatch stage that sits directly downstream of the instruction queue. It consumes the queue's slot pair (inst1/pc1, inst2/pc2) and returns stall1/stall2 in the same cycle.
- It decodes both slots and checks them against a 32-entry register scoreboard and against each other. It tracks reservation-station credits for the ALU and MEM classes.
- Accepted instructions go out on registered issue ports.

Parameters:
- RS_DEPTH, 4, entries per reservation-station class; reset and maximum value of each credit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst1  in  32  queue slot 1 instruction
- pc1  in  16  queue slot 1 PC
- inst2  in  32  queue slot 2 instruction
- pc2  in  16  queue slot 2 PC
- stall1  out  1  combinational; 1 = neither slot accepted
- stall2  out  1  combinational; 1 = slot 2 not accepted, only meaningful when stall1=0
- wb1_valid, wb2_valid  in  1  completion writeback valid
- wb1_reg, wb2_reg  in  5  completion destination register
- alu_rel, mem_rel  in  2  number of RS entries freed this cycle (0..2)
- iss1_valid, iss2_valid  out  1  issue valid
- iss1_pc, iss2_pc  out  16  issued PC
- iss1_inst, iss2_inst  out  32  issued instruction
- iss1_mem, iss2_mem  out  1  1 = MEM class, 0 = ALU class

Behaviour:
- Decode; op = inst[31:26].
  - inst == 0 is a NOP: no sources, no destination, no class, no credit.
  - op 0x00 (R-type): sources rs[25:21], rt[20:16]; destination rd[15:11]; ALU.
  - op 0x23 (lw): source rs; destination rt; MEM.
  - op 0x2B (sw): sources rs, rt; no destination; MEM.
  - op 0x04 (beq): sources rs, rt; no destination; ALU.
  - Any other op: source rs; destination rt; ALU.
  - Register 0 is never busy and is never a destination.
- Priming flag `primed`, reset 0.
  - While primed=0: stall1=0, stall2=0, no issue, so the queue loads its first pair.
  - primed goes to 1 on the next clk edge and stays 1.
  - inst/pc inputs are ignored while primed=0.
- ok1: primed, and no slot-1 source or destination is busy in the scoreboard, and its class credit is >= 1 (NOP is always ok).
- ok2: ok1, and all of the following:
  - no slot-2 source or destination is busy;
  - no slot-2 source equals the slot-1 destination (RAW);
  - the slot-2 destination differs from the slot-1 destination (WAW);
  - its class credit is >= 1 + (slot 1 same class ? 1 : 0).
- stall1 = primed & !ok1; stall2 = primed & ok1 & !ok2. Both are combinational from current inputs and registered state.
- The queue contract: stall2 alone causes the queue to re-present slot 2 as slot 1 next cycle; stall1 holds the pair.
- No same-cycle writeback bypass: a wb in cycle N unblocks a consumer in cycle N+1 at the earliest.
- Issue is registered, latency 1.
  - On the edge where slot k is accepted: issk_valid=1 and issk_pc/issk_inst/issk_mem capture that slot.
  - Otherwise issk_valid=0; data fields hold their old value.
  - An accepted NOP gives issk_valid=0.
- Scoreboard busy[31:0], per edge:
  - clear wb1_reg if wb1_valid; clear wb2_reg if wb2_valid;
  - then set the destinations of accepted slots;
  - a set wins over a clear of the same register in the same cycle.
- Credits alu_cnt and mem_cnt, 0..RS_DEPTH:
  - next = cnt - issued_in_class + rel;
  - saturate at RS_DEPTH; the simulation assertion flags overflow.
- Reset, asynchronous:
  - primed=0, busy=0, alu_cnt=mem_cnt=RS_DEPTH;
  - all iss* outputs 0;
  - stall1=stall2=0.
- Reset mid-operation discards all in-flight scoreboard and credit state.

Decomposition:
- Package dispatch_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ), class encoding, decoded-fields struct (src_a, src_a_v, src_b, src_b_v, dst, dst_v, mem, nop).
- Sub-module dispatch_decode: purely combinational, instruction to decoded fields. Instantiated twice, once per slot.

Test Plan:
- Reset release, then two cycles with independent add r3 / add r4 → cycle 1: stall1=0, stall2=0, no issue. Cycle 2: stall1=0, stall2=0. Next cycle: iss1_valid=1, iss2_valid=1, busy[3]=busy[4]=1, alu_cnt=2.
- Pair: add r5,r1,r2 / add r6,r5,r1 → stall2=1; only slot 1 issues. The next cycle (r5 busy) has stall1=1 until wb1_valid=1, wb1_reg=5. One cycle later stall1=0.
- Two lw with mem_cnt=1 → stall2=1; mem_cnt becomes 0. The next pair has stall1=1 until mem_rel=1, after which it dispatches.
- wb1_reg=7 clear and slot-1 issue writing r7 in the same cycle → busy[7]=1 after the edge.
- Pair with destination r0 and WAW r8/r8 → r0 never set busy; the WAW pair gives stall2=1.
- Assert rst_n=0 mid-stream with busy bits and reduced credits → immediately busy=0, credits=RS_DEPTH, iss*_valid=0, primed=0.

Source files
------------

// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - opcodes, class encoding and decoded-slot type for the dual dispatch stage
package dispatch_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef enum logic {
        CLS_ALU = 1'b0,
        CLS_MEM = 1'b1
    } op_class_e;

    typedef struct packed {
        logic [4:0] src_a;
        logic       src_a_v;
        logic [4:0] src_b;
        logic       src_b_v;
        logic [4:0] dst;
        logic       dst_v;
        logic       mem;
        logic       nop;
    } decoded_t;

    // Any operand of the slot (sources or destination) still owned by an in-flight producer
    function automatic logic uses_busy(input decoded_t d, input logic [31:0] busy);
        return (d.src_a_v && busy[d.src_a]) ||
               (d.src_b_v && busy[d.src_b]) ||
               (d.dst_v   && busy[d.dst]);
    endfunction

    function automatic logic reads_reg(input decoded_t d, input logic [4:0] r);
        return (d.src_a_v && (d.src_a == r)) || (d.src_b_v && (d.src_b == r));
    endfunction

endpackage

// File: rtl/dispatch_decode.sv
// rtl/dispatch_decode.sv - combinational instruction decode into operand/class fields
module dispatch_decode
    import dispatch_pkg::*;
(
    input  logic [31:0] inst,
    output decoded_t    dec
);

    logic [5:0] op;
    op_class_e  cls;

    assign op = inst[31:26];

    always_comb begin
        dec       = '0;
        cls       = CLS_ALU;
        dec.src_a = inst[25:21];
        dec.src_b = inst[20:16];
        dec.dst   = inst[20:16];
        if (inst == 32'd0) begin
            dec.nop = 1'b1;
        end else begin
            case (op)
                OP_RTYPE: begin
                    dec.src_a_v = 1'b1;
                    dec.src_b_v = 1'b1;
                    dec.dst     = inst[15:11];
                    dec.dst_v   = 1'b1;
                end
                OP_LW: begin
                    dec.src_a_v = 1'b1;
                    dec.dst_v   = 1'b1;
                    cls         = CLS_MEM;
                end
                OP_SW: begin
                    dec.src_a_v = 1'b1;
                    dec.src_b_v = 1'b1;
                    cls         = CLS_MEM;
                end
                OP_BEQ: begin
                    dec.src_a_v = 1'b1;
                    dec.src_b_v = 1'b1;
                end
                default: begin
                    dec.src_a_v = 1'b1;
                    dec.dst_v   = 1'b1;
                end
            endcase
        end
        // r0 is hardwired, so writing it creates no dependency
        if (dec.dst == 5'd0) dec.dst_v = 1'b0;
        dec.mem = (cls == CLS_MEM);
    end

endmodule

// File: rtl/dual_dispatch.sv
// rtl/dual_dispatch.sv - in-order two-wide dispatch with scoreboard and RS credit tracking
module dual_dispatch
    import dispatch_pkg::*;
#(
    parameter int RS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst1,
    input  logic [15:0] pc1,
    input  logic [31:0] inst2,
    input  logic [15:0] pc2,
    output logic        stall1,
    output logic        stall2,
    input  logic        wb1_valid,
    input  logic        wb2_valid,
    input  logic [4:0]  wb1_reg,
    input  logic [4:0]  wb2_reg,
    input  logic [1:0]  alu_rel,
    input  logic [1:0]  mem_rel,
    output logic        iss1_valid,
    output logic        iss2_valid,
    output logic [15:0] iss1_pc,
    output logic [15:0] iss2_pc,
    output logic [31:0] iss1_inst,
    output logic [31:0] iss2_inst,
    output logic        iss1_mem,
    output logic        iss2_mem
);

    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(RS_DEPTH);

    logic          primed;
    logic [31:0]   busy, busy_next, set_mask, clr_mask;
    logic [CW-1:0] alu_cnt, mem_cnt, alu_next, mem_next, cnt1, cnt2;
    logic [CW+1:0] alu_sum, mem_sum;
    logic [1:0]    alu_iss, mem_iss;
    logic          same_cls, credit1, credit2, ok1, ok2;
    decoded_t      d1, d2;

    dispatch_decode u_dec1 (.inst(inst1), .dec(d1));
    dispatch_decode u_dec2 (.inst(inst2), .dec(d2));

    always_comb begin
        cnt1     = d1.mem ? mem_cnt : alu_cnt;
        cnt2     = d2.mem ? mem_cnt : alu_cnt;
        same_cls = !d1.nop && (d1.mem == d2.mem);
        credit1  = d1.nop || (cnt1 != '0);
        credit2  = d2.nop || (int'(cnt2) >= (same_cls ? 2 : 1));
        ok1      = primed && !uses_busy(d1, busy) && credit1;
        ok2      = ok1 && !uses_busy(d2, busy) && credit2 &&
                   !(d1.dst_v && reads_reg(d2, d1.dst)) &&
                   !(d1.dst_v && d2.dst_v && (d1.dst == d2.dst));
    end

    assign stall1 = primed & ~ok1;
    assign stall2 = primed & ok1 & ~ok2;

    always_comb begin
        alu_iss = {1'b0, ok1 & ~d1.nop & ~d1.mem} + {1'b0, ok2 & ~d2.nop & ~d2.mem};
        mem_iss = {1'b0, ok1 & ~d1.nop &  d1.mem} + {1'b0, ok2 & ~d2.nop &  d2.mem};
        // Credit checks guarantee cnt >= issued, so the subtraction cannot wrap
        alu_sum  = (CW+2)'(alu_cnt) + (CW+2)'(alu_rel) - (CW+2)'(alu_iss);
        mem_sum  = (CW+2)'(mem_cnt) + (CW+2)'(mem_rel) - (CW+2)'(mem_iss);
        alu_next = (alu_sum > DEPTH_W) ? CW'(RS_DEPTH) : alu_sum[CW-1:0];
        mem_next = (mem_sum > DEPTH_W) ? CW'(RS_DEPTH) : mem_sum[CW-1:0];
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wb1_valid) clr_mask[wb1_reg] = 1'b1;
        if (wb2_valid) clr_mask[wb2_reg] = 1'b1;
        if (ok1 && d1.dst_v) set_mask[d1.dst] = 1'b1;
        if (ok2 && d2.dst_v) set_mask[d2.dst] = 1'b1;
        busy_next = (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed     <= 1'b0;
            busy       <= '0;
            alu_cnt    <= CW'(RS_DEPTH);
            mem_cnt    <= CW'(RS_DEPTH);
            iss1_valid <= 1'b0;
            iss2_valid <= 1'b0;
            iss1_pc    <= '0;
            iss2_pc    <= '0;
            iss1_inst  <= '0;
            iss2_inst  <= '0;
            iss1_mem   <= 1'b0;
            iss2_mem   <= 1'b0;
        end else begin
            primed     <= 1'b1;
            busy       <= busy_next;
            alu_cnt    <= alu_next;
            mem_cnt    <= mem_next;
            iss1_valid <= ok1 & ~d1.nop;
            iss2_valid <= ok2 & ~d2.nop;
            if (ok1) begin
                iss1_pc   <= pc1;
                iss1_inst <= inst1;
                iss1_mem  <= d1.mem;
            end
            if (ok2) begin
                iss2_pc   <= pc2;
                iss2_inst <= inst2;
                iss2_mem  <= d2.mem;
            end
        end
    end

    credit_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        (alu_sum <= DEPTH_W) && (mem_sum <= DEPTH_W));

endmodule

// File: tb/tb_dual_dispatch.sv
// tb/tb_dual_dispatch.sv - directed self-checking bench for dual_dispatch
module tb_dual_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst1, inst2;
    logic [15:0] pc1, pc2;
    logic        stall1, stall2;
    logic        wb1_valid, wb2_valid;
    logic [4:0]  wb1_reg, wb2_reg;
    logic [1:0]  alu_rel, mem_rel;
    logic        iss1_valid, iss2_valid;
    logic [15:0] iss1_pc, iss2_pc;
    logic [31:0] iss1_inst, iss2_inst;
    logic        iss1_mem, iss2_mem;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dual_dispatch #(.RS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst1(inst1), .pc1(pc1), .inst2(inst2), .pc2(pc2),
        .stall1(stall1), .stall2(stall2),
        .wb1_valid(wb1_valid), .wb2_valid(wb2_valid),
        .wb1_reg(wb1_reg), .wb2_reg(wb2_reg),
        .alu_rel(alu_rel), .mem_rel(mem_rel),
        .iss1_valid(iss1_valid), .iss2_valid(iss2_valid),
        .iss1_pc(iss1_pc), .iss2_pc(iss2_pc),
        .iss1_inst(iss1_inst), .iss2_inst(iss2_inst),
        .iss1_mem(iss1_mem), .iss2_mem(iss2_mem)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] add_i(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 11'h020};
    endfunction

    function automatic logic [31:0] lw_i(input int rt, input int rs);
        return {6'h23, 5'(rs), 5'(rt), 16'h0000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [31:0] i1, input logic [15:0] p1,
                        input logic [31:0] i2, input logic [15:0] p2);
        inst1 = i1; pc1 = p1; inst2 = i2; pc2 = p2;
    endtask

    task automatic quiet();
        wb1_valid = 1'b0; wb2_valid = 1'b0; wb1_reg = '0; wb2_reg = '0;
        alu_rel = '0; mem_rel = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        quiet();
        pair('0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall1", 32'(stall1), 0);
        chk("rst_stall2", 32'(stall2), 0);
        chk("rst_iss1_valid", 32'(iss1_valid), 0);
        chk("rst_iss2_valid", 32'(iss2_valid), 0);
        chk("rst_primed", 32'(dut.primed), 0);
        chk("rst_busy", dut.busy, 0);
        chk("rst_alu_cnt", 32'(dut.alu_cnt), 4);
        chk("rst_mem_cnt", 32'(dut.mem_cnt), 4);

        // Priming cycle, then independent pair
        @(negedge clk);
        rst_n = 1'b1;
        pair(add_i(3, 1, 2), 16'h0100, add_i(4, 1, 2), 16'h0104);
        #1;
        chk("prime_stall1", 32'(stall1), 0);
        chk("prime_stall2", 32'(stall2), 0);
        tick();
        chk("prime_no_iss1", 32'(iss1_valid), 0);
        chk("prime_no_iss2", 32'(iss2_valid), 0);
        chk("primed_set", 32'(dut.primed), 1);
        @(negedge clk);
        chk("indep_stall1", 32'(stall1), 0);
        chk("indep_stall2", 32'(stall2), 0);
        tick();
        chk("indep_iss1_valid", 32'(iss1_valid), 1);
        chk("indep_iss2_valid", 32'(iss2_valid), 1);
        chk("indep_iss1_pc", 32'(iss1_pc), 32'h0100);
        chk("indep_iss2_pc", 32'(iss2_pc), 32'h0104);
        chk("indep_iss2_inst", iss2_inst, add_i(4, 1, 2));
        chk("indep_iss1_mem", 32'(iss1_mem), 0);
        chk("indep_busy", dut.busy, 32'h0000_0018);
        chk("indep_alu_cnt", 32'(dut.alu_cnt), 2);

        // RAW pair; retire r3/r4 and return two ALU credits alongside
        pair(add_i(5, 1, 2), 16'h0108, add_i(6, 5, 1), 16'h010C);
        wb1_valid = 1'b1; wb1_reg = 5'd3; wb2_valid = 1'b1; wb2_reg = 5'd4; alu_rel = 2'd2;
        @(negedge clk);
        chk("raw_stall1", 32'(stall1), 0);
        chk("raw_stall2", 32'(stall2), 1);
        tick();
        quiet();
        chk("raw_iss1_valid", 32'(iss1_valid), 1);
        chk("raw_iss1_pc", 32'(iss1_pc), 32'h0108);
        chk("raw_iss2_valid", 32'(iss2_valid), 0);
        chk("raw_busy", dut.busy, 32'h0000_0020);
        chk("raw_alu_cnt", 32'(dut.alu_cnt), 3);

        // Consumer of r5 shifts to slot 1 and waits for writeback
        pair(add_i(6, 5, 1), 16'h010C, 32'd0, 16'h0110);
        @(negedge clk);
        chk("dep_stall1", 32'(stall1), 1);
        tick();
        chk("dep_no_iss", 32'(iss1_valid), 0);
        wb1_valid = 1'b1; wb1_reg = 5'd5;
        @(negedge clk);
        chk("wb_no_bypass_stall1", 32'(stall1), 1);
        tick();
        quiet();
        chk("wb_busy_clear", dut.busy, 0);
        @(negedge clk);
        chk("dep_go_stall1", 32'(stall1), 0);
        chk("dep_go_stall2", 32'(stall2), 0);
        tick();
        chk("dep_iss1_valid", 32'(iss1_valid), 1);
        chk("dep_iss1_pc", 32'(iss1_pc), 32'h010C);
        chk("nop_iss2_valid", 32'(iss2_valid), 0);
        chk("dep_busy", dut.busy, 32'h0000_0040);
        chk("dep_alu_cnt", 32'(dut.alu_cnt), 2);

        // Drain MEM credits down to one
        pair(lw_i(10, 1), 16'h0200, lw_i(11, 1), 16'h0204);
        @(negedge clk);
        chk("lw_a_stall2", 32'(stall2), 0);
        tick();
        chk("lw_a_iss2_mem", 32'(iss2_mem), 1);
        chk("lw_a_mem_cnt", 32'(dut.mem_cnt), 2);
        pair(lw_i(12, 1), 16'h0208, 32'd0, 16'h020C);
        tick();
        chk("lw_b_mem_cnt", 32'(dut.mem_cnt), 1);
        pair(lw_i(13, 1), 16'h0210, lw_i(14, 1), 16'h0214);
        @(negedge clk);
        chk("mem1_stall1", 32'(stall1), 0);
        chk("mem1_stall2", 32'(stall2), 1);
        tick();
        chk("mem1_iss1_valid", 32'(iss1_valid), 1);
        chk("mem1_iss2_valid", 32'(iss2_valid), 0);
        chk("mem1_mem_cnt", 32'(dut.mem_cnt), 0);
        pair(lw_i(14, 1), 16'h0214, 32'd0, 16'h0218);
        @(negedge clk);
        chk("mem0_stall1", 32'(stall1), 1);
        tick();
        mem_rel = 2'd1;
        @(negedge clk);
        chk("mem_rel_stall1", 32'(stall1), 1);
        tick();
        quiet();
        chk("mem_rel_cnt", 32'(dut.mem_cnt), 1);
        @(negedge clk);
        chk("mem_go_stall1", 32'(stall1), 0);
        tick();
        chk("mem_go_iss1_valid", 32'(iss1_valid), 1);
        chk("mem_go_iss1_pc", 32'(iss1_pc), 32'h0214);
        chk("mem_go_iss1_mem", 32'(iss1_mem), 1);
        chk("mem_go_cnt", 32'(dut.mem_cnt), 0);
        chk("mem_go_busy", dut.busy, 32'h0000_7C40);

        // Writeback clear and new set of r7 on the same edge
        pair(add_i(7, 1, 2), 16'h0300, 32'd0, 16'h0304);
        wb1_valid = 1'b1; wb1_reg = 5'd7; alu_rel = 2'd1;
        tick();
        quiet();
        chk("setclr_busy7", 32'(dut.busy[7]), 1);
        chk("setclr_alu_cnt", 32'(dut.alu_cnt), 2);

        // Both slots target r0: no WAW, no busy bit
        pair(add_i(0, 1, 2), 16'h0308, add_i(0, 2, 1), 16'h030C);
        alu_rel = 2'd2;
        @(negedge clk);
        chk("r0_stall2", 32'(stall2), 0);
        tick();
        quiet();
        chk("r0_iss2_valid", 32'(iss2_valid), 1);
        chk("r0_busy", dut.busy, 32'h0000_7CC0);
        chk("r0_alu_cnt", 32'(dut.alu_cnt), 2);

        // WAW on r8
        pair(add_i(8, 1, 2), 16'h0310, add_i(8, 2, 1), 16'h0314);
        @(negedge clk);
        chk("waw_stall1", 32'(stall1), 0);
        chk("waw_stall2", 32'(stall2), 1);
        tick();
        chk("waw_iss1_valid", 32'(iss1_valid), 1);
        chk("waw_iss2_valid", 32'(iss2_valid), 0);
        chk("waw_busy", dut.busy, 32'h0000_7DC0);
        chk("waw_alu_cnt", 32'(dut.alu_cnt), 1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", dut.busy, 0);
        chk("mid_rst_alu_cnt", 32'(dut.alu_cnt), 4);
        chk("mid_rst_mem_cnt", 32'(dut.mem_cnt), 4);
        chk("mid_rst_iss1_valid", 32'(iss1_valid), 0);
        chk("mid_rst_primed", 32'(dut.primed), 0);
        chk("mid_rst_stall1", 32'(stall1), 0);
        chk("mid_rst_stall2", 32'(stall2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
